// File: rtl/pri_arb.sv
`default_nettype none
// ============================================================================
// Module : pri_arb
// Desc   : Grant arbiter with fixed or round-robin priority; grant held until ack
// Rev    : 1.0
// ============================================================================
module pri_arb #(
    parameter int W  = 4,
    parameter int RR = 1
) (
    input  logic                                    clk,
    input  logic                                    arst,
    input  logic [W-1:0]                            i_req,
    input  logic                                    i_ack,
    output logic [W-1:0]                            o_gnt,
    output logic                                    o_gnt_vld,
    output logic [((W > 1) ? $clog2(W) : 1)-1:0]    o_gnt_idx
);

    localparam int IW = (W > 1) ? $clog2(W) : 1;

    typedef enum logic [0:0] {
        IDLE  = 1'b0,
        GRANT = 1'b1
    } state_t;

    state_t          state_q;
    logic [W-1:0]    gnt_q;
    logic            vld_q;
    logic [IW-1:0]   idx_q;
    logic [IW-1:0]   last_idx_q;
    logic [IW-1:0]   last_idx_d;

    logic            ack_grant;
    logic [W-1:0]    lo_mask;
    logic [2*W-1:0]  req_dbl;
    logic            sel_any;
    logic [IW-1:0]   sel_idx;
    logic [W-1:0]    sel_gnt;

    assign ack_grant = (state_q == GRANT) && i_ack;

    // The pointer update is visible to the same-cycle re-arbitration.
    always_comb begin
        last_idx_d = last_idx_q;
        if (ack_grant && (RR != 0)) begin
            last_idx_d = idx_q;
        end
    end

    // Upper half holds requests strictly below the pointer, so they win first;
    // the lower half covers the wrap back down from W-1 to the pointer.
    always_comb begin
        for (int i = 0; i < W; i++) begin
            lo_mask[i] = (i < int'(last_idx_d));
        end
    end

    assign req_dbl = {i_req & lo_mask, i_req};
    assign sel_any = |i_req;

    always_comb begin
        sel_idx = '0;
        for (int i = 0; i < 2*W; i++) begin
            if (req_dbl[i]) begin
                sel_idx = (i < W) ? IW'(i) : IW'(i - W);
            end
        end
    end

    always_comb begin
        for (int i = 0; i < W; i++) begin
            sel_gnt[i] = (IW'(i) == sel_idx);
        end
    end

    always_ff @(posedge clk or posedge arst) begin
        if (arst) begin
            state_q    <= IDLE;
            last_idx_q <= '0;
            gnt_q      <= '0;
            vld_q      <= 1'b0;
            idx_q      <= '0;
        end else begin
            last_idx_q <= last_idx_d;
            case (state_q)
                IDLE: begin
                    if (sel_any) begin
                        state_q <= GRANT;
                        gnt_q   <= sel_gnt;
                        idx_q   <= sel_idx;
                        vld_q   <= 1'b1;
                    end else begin
                        gnt_q   <= '0;
                        idx_q   <= '0;
                        vld_q   <= 1'b0;
                    end
                end
                GRANT: begin
                    if (i_ack) begin
                        if (sel_any) begin
                            gnt_q   <= sel_gnt;
                            idx_q   <= sel_idx;
                            vld_q   <= 1'b1;
                        end else begin
                            state_q <= IDLE;
                            gnt_q   <= '0;
                            idx_q   <= '0;
                            vld_q   <= 1'b0;
                        end
                    end
                end
                default: begin
                    state_q <= IDLE;
                    gnt_q   <= '0;
                    idx_q   <= '0;
                    vld_q   <= 1'b0;
                end
            endcase
        end
    end

    assign o_gnt     = gnt_q;
    assign o_gnt_vld = vld_q;
    assign o_gnt_idx = idx_q;

endmodule
`default_nettype wire

// File: tb/tb_pri_arb.sv
`default_nettype none
// ============================================================================
// Module : tb_pri_arb
// Desc   : Scoreboard bench for pri_arb (W=4 RR, W=4 fixed, W=1) vs. a queue model
// Rev    : 1.0
// ============================================================================
module tb_pri_arb;

    logic       clk = 1'b0;
    logic       arst;
    logic [3:0] req_rr, req_fx;
    logic       ack_rr, ack_fx, req_w1, ack_w1;
    logic [3:0] gnt_rr, gnt_fx;
    logic       gnt_w1;
    logic       vld_rr, vld_fx, vld_w1;
    logic [1:0] idx_rr, idx_fx;
    logic       idx_w1;

    int checks = 0;
    int errors = 0;
    int rr_seq[5];

    typedef struct packed {
        logic [2:0]      vld;
        logic [2:0][3:0] gnt;
        logic [2:0][1:0] idx;
    } exp_t;

    exp_t sbq[$];
    bit   busy[3];
    int   cur[3];
    int   last[3];

    always #5 clk = ~clk;

    pri_arb #(.W(4), .RR(1)) u_rr (
        .clk(clk), .arst(arst), .i_req(req_rr), .i_ack(ack_rr),
        .o_gnt(gnt_rr), .o_gnt_vld(vld_rr), .o_gnt_idx(idx_rr)
    );
    pri_arb #(.W(4), .RR(0)) u_fx (
        .clk(clk), .arst(arst), .i_req(req_fx), .i_ack(ack_fx),
        .o_gnt(gnt_fx), .o_gnt_vld(vld_fx), .o_gnt_idx(idx_fx)
    );
    pri_arb #(.W(1), .RR(1)) u_w1 (
        .clk(clk), .arst(arst), .i_req(req_w1), .i_ack(ack_w1),
        .o_gnt(gnt_w1), .o_gnt_vld(vld_w1), .o_gnt_idx(idx_w1)
    );

    // Walk the priority order downward from just below the pointer, wrapping.
    function automatic int pick(int n, logic [3:0] r, int lst);
        for (int k = 1; k <= n; k++) begin
            int c;
            c = (lst - k + n) % n;
            if (r[c]) return c;
        end
        return 0;
    endfunction

    task automatic chk(string nm, int act, int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic sb_cmp(string nm, logic v, logic [3:0] g, logic [1:0] ix,
                          logic ev, logic [3:0] eg, logic [1:0] ei);
        checks++;
        if (v !== ev || g !== eg || ix !== ei) begin
            errors++;
            $display("FAIL %s: got vld=%0b gnt=%b idx=%0d expected vld=%0b gnt=%b idx=%0d at %0t",
                     nm, v, g, ix, ev, eg, ei, $time);
        end
    endtask

    // Reference model: pushes the expected post-edge outputs of all three DUTs.
    initial begin : model
        exp_t       e;
        logic [3:0] r;
        logic       a;
        int         n;
        forever begin
            @(posedge clk or posedge arst);
            if (arst) begin
                for (int d = 0; d < 3; d++) begin
                    busy[d] = 1'b0;
                    cur[d]  = 0;
                    last[d] = 0;
                end
                sbq.delete();
            end else begin
                e = '0;
                for (int d = 0; d < 3; d++) begin
                    r = (d == 0) ? req_rr : (d == 1) ? req_fx : {3'b000, req_w1};
                    a = (d == 0) ? ack_rr : (d == 1) ? ack_fx : ack_w1;
                    n = (d == 2) ? 1 : 4;
                    if (!busy[d]) begin
                        if (r != 4'b0) begin
                            cur[d]  = pick(n, r, last[d]);
                            busy[d] = 1'b1;
                        end
                    end else if (a) begin
                        if (d != 1) last[d] = cur[d];
                        if (r != 4'b0) cur[d] = pick(n, r, last[d]);
                        else busy[d] = 1'b0;
                    end
                    if (busy[d]) begin
                        e.vld[d] = 1'b1;
                        e.gnt[d] = 4'b0001 << cur[d];
                        e.idx[d] = 2'(cur[d]);
                    end
                end
                sbq.push_back(e);
            end
        end
    end

    initial begin : monitor
        exp_t e;
        forever begin
            @(negedge clk);
            if (!arst && sbq.size() > 0) begin
                e = sbq.pop_front();
                sb_cmp("sb_rr", vld_rr, gnt_rr, idx_rr, e.vld[0], e.gnt[0], e.idx[0]);
                sb_cmp("sb_fx", vld_fx, gnt_fx, idx_fx, e.vld[1], e.gnt[1], e.idx[1]);
                sb_cmp("sb_w1", vld_w1, {3'b000, gnt_w1}, {1'b0, idx_w1},
                       e.vld[2], e.gnt[2], e.idx[2]);
            end
        end
    end

    initial begin : watchdog
        #200000;
        errors++;
        $display("FAIL watchdog: simulation did not complete in time");
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin : driver
        arst   = 1'b1;
        req_rr = 4'b0; ack_rr = 1'b0;
        req_fx = 4'b0; ack_fx = 1'b0;
        req_w1 = 1'b0; ack_w1 = 1'b0;
        rr_seq = '{3, 2, 1, 0, 3};
        repeat (3) @(negedge clk);
        chk("rst_noX", int'($isunknown({gnt_rr, vld_rr, idx_rr, gnt_fx, vld_fx, idx_fx,
                                        gnt_w1, vld_w1, idx_w1})), 0);
        chk("rst_vld_rr", int'(vld_rr), 0);
        chk("rst_gnt_rr", int'(gnt_rr), 0);
        chk("rst_idx_rr", int'(idx_rr), 0);
        chk("rst_vld_fx", int'(vld_fx), 0);
        chk("rst_vld_w1", int'(vld_w1), 0);
        arst = 1'b0;

        // Round-robin rotation and fixed-priority starvation with all requesting.
        req_rr = 4'hF; ack_rr = 1'b1;
        req_fx = 4'hF; ack_fx = 1'b1;
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            chk("rr_seq_idx", int'(idx_rr), rr_seq[k]);
            chk("rr_seq_vld", int'(vld_rr), 1);
            chk("fx_hold3", int'(idx_fx), 3);
        end
        req_fx = 4'b0101;
        repeat (3) begin
            @(negedge clk);
            chk("fx_hold2", int'(idx_fx), 2);
        end

        // Grant held stable without ack, then order resumes below idx 2.
        req_rr = 4'b0100; ack_rr = 1'b1;
        @(negedge clk);
        chk("rr_g2_idx", int'(idx_rr), 2);
        ack_rr = 1'b0; req_rr = 4'b1001;
        repeat (5) begin
            @(negedge clk);
            chk("rr_hold_gnt", int'(gnt_rr), 4'b0100);
        end
        ack_rr = 1'b1;
        @(negedge clk);
        chk("rr_after_hold", int'(idx_rr), 0);

        // Drop to IDLE, then a single grant with release.
        req_rr = 4'b0; ack_rr = 1'b1;
        @(negedge clk);
        chk("rr_idle_vld", int'(vld_rr), 0);
        req_rr = 4'b0010; ack_rr = 1'b0;
        @(negedge clk);
        chk("rr_single_idx", int'(idx_rr), 1);
        chk("rr_single_vld", int'(vld_rr), 1);
        req_rr = 4'b0; ack_rr = 1'b1;
        @(negedge clk);
        chk("rr_release_vld", int'(vld_rr), 0);
        chk("rr_release_gnt", int'(gnt_rr), 0);

        // Stray ack while idle must not move the pointer (still 1).
        repeat (2) begin
            @(negedge clk);
            chk("rr_stray_vld", int'(vld_rr), 0);
            chk("rr_stray_idx", int'(idx_rr), 0);
        end
        req_rr = 4'hF; ack_rr = 1'b0;
        @(negedge clk);
        chk("rr_ptr_kept", int'(idx_rr), 0);

        // Build grant idx 1 with pointer 3, then reset asynchronously mid-cycle.
        req_rr = 4'b1000; ack_rr = 1'b1;
        @(negedge clk);
        chk("rr_pre_rst3", int'(idx_rr), 3);
        req_rr = 4'b0010;
        @(negedge clk);
        chk("rr_pre_rst1", int'(idx_rr), 1);
        ack_rr = 1'b0;
        #2 arst = 1'b1;
        #1;
        chk("arst_vld_rr", int'(vld_rr), 0);
        chk("arst_gnt_rr", int'(gnt_rr), 0);
        chk("arst_idx_rr", int'(idx_rr), 0);
        chk("arst_vld_fx", int'(vld_fx), 0);
        #1 arst = 1'b0;
        req_rr = 4'hF;
        @(negedge clk);
        chk("post_rst_idx", int'(idx_rr), 3);
        chk("post_rst_vld", int'(vld_rr), 1);

        // Single requester with ack toggling keeps a continuous grant.
        req_w1 = 1'b1;
        for (int k = 0; k < 6; k++) begin
            ack_w1 = k[0];
            @(negedge clk);
            chk("w1_gnt", int'(gnt_w1), 1);
            chk("w1_idx", int'(idx_w1), 0);
        end

        // Randomised traffic, checked by the scoreboard.
        repeat (400) begin
            @(negedge clk);
            req_rr = 4'($urandom) & 4'($urandom | 32'h5);
            req_fx = 4'($urandom) & 4'($urandom);
            ack_rr = ($urandom_range(0, 3) != 0);
            ack_fx = $urandom_range(0, 1) == 1;
            req_w1 = $urandom_range(0, 2) != 0;
            ack_w1 = $urandom_range(0, 1) == 1;
        end
        repeat (2) @(negedge clk);
        chk("sb_drained", sbq.size() <= 1 ? 1 : 0, 1);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
